name_render_sequencer: RTL and testbench
========================================

Name: name_render_sequencer

Overview:
- Sequences rendering of the captured name string onto the TFT.
- On each `name_ready` pulse from the name capture block it snapshots the name, buffer, length and font size.
- It then issues one region-clear request, followed by one glyph-draw request per character, to the TFT glyph renderer over a req/ack handshake.
- It computes per-character scale and screen position, and truncates characters that would overrun the screen edge.

Parameters:
- MAX_NAME_LENGTH, 10, capacity of the name buffer in characters.
- GLYPH_WIDTH, 8, unscaled glyph width in pixels.
- GLYPH_HEIGHT, 16, unscaled glyph height in pixels.
- SCREEN_WIDTH, 240, drawable width in pixels; exclusive right bound.
- ORIGIN_X, 0, x pixel of the first character.
- ORIGIN_Y, 0, y pixel of the text row.
- COORD_WIDTH, 9, width of the coordinate outputs.

Ports:
- system_clock  in  1  sole clock.
- system_reset  in  1  asynchronous, active-high reset.
- name_buffer  in  8*MAX_NAME_LENGTH  characters; char i is bits [8i+7:8i].
- name_length  in  6  number of valid characters.
- font_size  in  2  size code 0..3.
- name_ready  in  1  one-cycle request to (re)render.
- clear_req  out  1  request to clear the text region.
- clear_ack  in  1  renderer accepted the clear.
- char_req  out  1  request to draw one glyph.
- char_ack  in  1  renderer accepted the glyph.
- char_code  out  8  ASCII code of the glyph.
- char_x  out  COORD_WIDTH  left pixel of the glyph.
- char_y  out  COORD_WIDTH  top pixel of the glyph; always ORIGIN_Y.
- char_scale  out  3  integer scale, equal to font_size+1 (1..4).
- busy  out  1  high from snapshot until the end of DONE.
- frame_done  out  1  one-cycle pulse when a render completes.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Pending flag and snapshot registers are cleared.
- Reset asserted mid-operation aborts immediately. Any req drops asynchronously and no frame_done is produced.
- FSM states: IDLE, CLEAR, CHAR, CHAR_NEXT, DONE.
- IDLE:
  - On the edge sampling name_ready=1, snapshot buffer, length and font_size.
  - Clamp length to MAX_NAME_LENGTH.
  - Set index=0 and go to CLEAR. clear_req and busy are high in the next cycle (1-cycle latency).
- CLEAR:
  - clear_req is held high until clear_ack=1 is sampled.
  - On that edge, clear_req drops. If the length is 0, go to DONE; otherwise go to CHAR.
- CHAR:
  - char_req is high with char_code = snapshot char[index] and char_x = ORIGIN_X + index*GLYPH_WIDTH*scale.
  - char_code, char_x, char_y and char_scale are stable while char_req is high.
  - On the edge sampling char_ack=1, char_req drops and the FSM goes to CHAR_NEXT.
- CHAR_NEXT (one cycle):
  - index increments.
  - Go to DONE if index == length, or if the next glyph would overrun: ORIGIN_X + (index+1)*GLYPH_WIDTH*scale > SCREEN_WIDTH.
  - Otherwise go to CHAR.
  - The overrun check also applies before the first glyph; if glyph 0 cannot fit, go to DONE without any char_req.
- DONE (one cycle):
  - frame_done=1.
  - If the pending flag is set, clear it, re-snapshot the current inputs and go to CLEAR.
  - Otherwise go to IDLE. busy drops on entry to IDLE.
- Arithmetic:
  - Position math uses at least COORD_WIDTH+4 bits internally so it cannot wrap.
  - char_x is the low COORD_WIDTH bits of a value already bounded by SCREEN_WIDTH.
- Handshakes:
  - clear_req and char_req are never high simultaneously.
  - An ack sampled while the matching req is low is ignored.
  - A req never drops without a sampled ack, except on reset.
- Simultaneous events:
  - name_ready while not in IDLE sets the pending flag. Multiple such pulses collapse to one.
  - name_ready in the DONE cycle counts as pending, so it triggers an immediate re-render.
  - Input changes after the snapshot have no effect on the current frame.

Test Plan:
- Basic render: "AB", length 2, font 0, renderer acks 1 cycle after each req.
  - Required: one clear, then char 0x41 at x=0, scale 1, then char 0x42 at x=8.
  - frame_done pulses exactly once; busy is low afterwards.
- Scaling: font 2 with "XYZ".
  - Required: scale 3, x = 0, 24, 48.
  - Changing font_size to 0 mid-frame leaves the outputs unchanged.
- Truncation: font 3 (scale 4), 10 chars, SCREEN_WIDTH 240.
  - Required: exactly 7 char_req (x = 0..192, step 32), then frame_done.
  - Empty name (length 0): one clear, no char_req, then frame_done.
- Back-pressure and pending:
  - Hold char_ack low for 20 cycles; char outputs stay constant and req stays high.
  - Pulse name_ready twice during the frame.
  - Required: exactly one additional full render after the first frame_done.
- Reset abort: assert system_reset while char_req is high for index 1.
  - Required: all outputs go to 0 immediately, no frame_done.
  - After release, the next name_ready renders from index 0.

Source files
------------

// File: rtl/name_render_sequencer.sv
// rtl/name_render_sequencer.sv - sequences region clear and per-glyph draw requests for the captured name
`timescale 1ns/1ps
module name_render_sequencer #(
  parameter int MAX_NAME_LENGTH = 10,
  parameter int GLYPH_WIDTH     = 8,
  parameter int GLYPH_HEIGHT    = 16,
  parameter int SCREEN_WIDTH    = 240,
  parameter int ORIGIN_X        = 0,
  parameter int ORIGIN_Y        = 0,
  parameter int COORD_WIDTH     = 9
) (
  input  logic                         system_clock,
  input  logic                         system_reset,
  input  logic [8*MAX_NAME_LENGTH-1:0] name_buffer,
  input  logic [5:0]                   name_length,
  input  logic [1:0]                   font_size,
  input  logic                         name_ready,
  output logic                         clear_req,
  input  logic                         clear_ack,
  output logic                         char_req,
  input  logic                         char_ack,
  output logic [7:0]                   char_code,
  output logic [COORD_WIDTH-1:0]       char_x,
  output logic [COORD_WIDTH-1:0]       char_y,
  output logic [2:0]                   char_scale,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int POS_W = COORD_WIDTH + 4;
  localparam int IDX_W = 6;

  if (GLYPH_WIDTH <= 0 || GLYPH_HEIGHT <= 0) begin : g_bad_glyph
    $error("name_render_sequencer: glyph dimensions must be positive");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CHAR,
    CHAR_NEXT,
    DONE
  } state_t;

  state_t                       state;
  logic                         pending;
  logic [8*MAX_NAME_LENGTH-1:0] snap_buffer;
  logic [IDX_W-1:0]             snap_length;
  logic [2:0]                   snap_scale;
  logic [IDX_W-1:0]             index;

  logic [IDX_W-1:0] clamped_length;
  logic [IDX_W-1:0] next_index;
  logic [POS_W-1:0] next_x;
  logic [POS_W-1:0] next_right;
  logic             next_fits;
  logic [7:0]       next_code;

  assign clamped_length = (name_length > IDX_W'(MAX_NAME_LENGTH)) ?
                          IDX_W'(MAX_NAME_LENGTH) : name_length;

  // Everything about the glyph that would be issued next: from CLEAR that is
  // glyph 0, from CHAR_NEXT it is the one after the current index.
  always_comb begin
    next_index = (state == CLEAR) ? '0 : index + IDX_W'(1);
    next_x     = POS_W'(ORIGIN_X) +
                 POS_W'(next_index) * POS_W'(GLYPH_WIDTH) * POS_W'(snap_scale);
    next_right = next_x + POS_W'(GLYPH_WIDTH) * POS_W'(snap_scale);
    next_fits  = (next_right <= POS_W'(SCREEN_WIDTH));
    next_code  = '0;
    for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
      if (next_index == IDX_W'(k)) begin
        next_code = snap_buffer[8*k +: 8];
      end
    end
  end

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      snap_buffer <= '0;
      snap_length <= '0;
      snap_scale  <= '0;
      index       <= '0;
      clear_req   <= 1'b0;
      char_req    <= 1'b0;
      char_code   <= '0;
      char_x      <= '0;
      char_y      <= '0;
      char_scale  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (name_ready) begin
            snap_buffer <= name_buffer;
            snap_length <= clamped_length;
            snap_scale  <= {1'b0, font_size} + 3'd1;
            index       <= '0;
            clear_req   <= 1'b1;
            busy        <= 1'b1;
            state       <= CLEAR;
          end
        end

        CLEAR: begin
          if (name_ready) begin
            pending <= 1'b1;
          end
          if (clear_ack) begin
            clear_req <= 1'b0;
            index     <= '0;
            if (snap_length == '0 || !next_fits) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              char_req   <= 1'b1;
              char_code  <= next_code;
              char_x     <= next_x[COORD_WIDTH-1:0];
              char_y     <= COORD_WIDTH'(ORIGIN_Y);
              char_scale <= snap_scale;
              state      <= CHAR;
            end
          end
        end

        CHAR: begin
          if (name_ready) begin
            pending <= 1'b1;
          end
          if (char_ack) begin
            char_req <= 1'b0;
            state    <= CHAR_NEXT;
          end
        end

        CHAR_NEXT: begin
          if (name_ready) begin
            pending <= 1'b1;
          end
          index <= next_index;
          if (next_index == snap_length || !next_fits) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            char_req   <= 1'b1;
            char_code  <= next_code;
            char_x     <= next_x[COORD_WIDTH-1:0];
            char_y     <= COORD_WIDTH'(ORIGIN_Y);
            char_scale <= snap_scale;
            state      <= CHAR;
          end
        end

        DONE: begin
          // A request arriving in this very cycle is folded into the pending one.
          if (pending || name_ready) begin
            pending     <= 1'b0;
            snap_buffer <= name_buffer;
            snap_length <= clamped_length;
            snap_scale  <= {1'b0, font_size} + 3'd1;
            index       <= '0;
            clear_req   <= 1'b1;
            state       <= CLEAR;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_name_render_sequencer.sv
// tb/tb_name_render_sequencer.sv - randomized self-checking bench for name_render_sequencer
`timescale 1ns/1ps
module tb_name_render_sequencer;

  localparam int MAXN = 10;
  localparam int GW   = 8;
  localparam int SW   = 240;
  localparam int OX   = 0;
  localparam int OY   = 0;

  logic            system_clock = 1'b0;
  logic            system_reset;
  logic [8*MAXN-1:0] name_buffer;
  logic [5:0]      name_length;
  logic [1:0]      font_size;
  logic            name_ready;
  logic            clear_req;
  logic            clear_ack;
  logic            char_req;
  logic            char_ack;
  logic [7:0]      char_code;
  logic [8:0]      char_x;
  logic [8:0]      char_y;
  logic [2:0]      char_scale;
  logic            busy;
  logic            frame_done;

  name_render_sequencer dut (
    .system_clock (system_clock),
    .system_reset (system_reset),
    .name_buffer  (name_buffer),
    .name_length  (name_length),
    .font_size    (font_size),
    .name_ready   (name_ready),
    .clear_req    (clear_req),
    .clear_ack    (clear_ack),
    .char_req     (char_req),
    .char_ack     (char_ack),
    .char_code    (char_code),
    .char_x       (char_x),
    .char_y       (char_y),
    .char_scale   (char_scale),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 system_clock = ~system_clock;

  // Expected render events: kind 0 = clear, 1 = glyph, 2 = frame done.
  typedef struct {
    int kind;
    int code;
    int x;
    int scale;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  bit  model_pending = 0;
  bit  respawn_next  = 0;

  int total_checks = 0;
  int bad_checks   = 0;
  int fd_count = 0, clr_count = 0, chr_count = 0;

  int dly_lo = 0, dly_hi = 1;
  bit spurious = 0;
  bit hold_next = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total_checks++;
    if (got != exp) begin
      bad_checks++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [8*MAXN-1:0] b, input logic [5:0] l,
                                     input logic [1:0] f);
    ev_t e;
    int  n;
    int  s;
    n = (int'(l) > MAXN) ? MAXN : int'(l);
    s = int'(f) + 1;
    e = '{0, 0, 0, 0, 0};
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      if (OX + (k + 1) * GW * s > SW) break;
      e.kind  = 1;
      e.code  = int'(b[8*k +: 8]);
      e.x     = OX + k * GW * s;
      e.scale = s;
      e.idx   = k;
      exp_q.push_back(e);
    end
    e = '{2, 0, 0, 0, 0};
    exp_q.push_back(e);
  endfunction

  task automatic expect_event(input string tag, input int kind, input int seen);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, seen, 0);
    end else begin
      check_eq({tag, "_order"}, kind, exp_q[0].kind);
      exp_q.delete(0);
    end
  endtask

  // Monitor: samples just after each rising edge.
  initial begin
    bit pc_clr;
    bit pc_chr;
    pc_clr = 0;
    pc_chr = 0;
    forever begin
      @(posedge system_clock);
      #2;
      if (system_reset) begin
        pc_clr = 0;
        pc_chr = 0;
        continue;
      end
      if (respawn_next) begin
        push_frame(name_buffer, name_length, font_size);
        respawn_next = 0;
      end
      if (pc_clr && clear_ack) begin
        clr_count++;
        expect_event("clear_accept", 0, 1);
      end
      if (pc_chr && char_ack) begin
        chr_count++;
        expect_event("char_accept", 1, 1);
      end
      if (pc_clr && !clear_ack) check_eq("clear_req_held", int'(clear_req), 1);
      if (pc_chr && !char_ack)  check_eq("char_req_held", int'(char_req), 1);
      check_eq("req_exclusive", int'(clear_req & char_req), 0);
      if (clear_req || char_req) begin
        if (exp_q.size() == 0) begin
          check_eq("req_unexpected", int'(clear_req | char_req), 0);
        end else begin
          check_eq("req_kind", clear_req ? 0 : 1, exp_q[0].kind);
          if (char_req) begin
            check_eq("char_code",  int'(char_code),  exp_q[0].code);
            check_eq("char_x",     int'(char_x),     exp_q[0].x);
            check_eq("char_y",     int'(char_y),     OY);
            check_eq("char_scale", int'(char_scale), exp_q[0].scale);
          end
        end
      end
      check_eq("busy", int'(busy), (exp_q.size() != 0) ? 1 : 0);
      if (frame_done) begin
        fd_count++;
        expect_event("frame_done", 2, 1);
        if (model_pending) begin
          respawn_next  = 1;
          model_pending = 0;
        end
      end
      pc_clr = clear_req;
      pc_chr = char_req;
    end
  end

  // Renderer model: acks after a random delay, optionally toggles acks while idle.
  initial begin
    int clr_dly, chr_dly, clr_cnt, chr_cnt;
    clear_ack = 0;
    char_ack  = 0;
    clr_dly = -1; chr_dly = -1; clr_cnt = 0; chr_cnt = 0;
    forever begin
      @(negedge system_clock);
      if (system_reset) begin
        clear_ack = 0;
        char_ack  = 0;
        clr_dly = -1; chr_dly = -1; clr_cnt = 0; chr_cnt = 0;
      end else begin
        if (clear_req) begin
          if (clr_dly < 0) begin
            clr_dly = int'($urandom_range(dly_hi, dly_lo));
            clr_cnt = 0;
          end
          if (clr_cnt >= clr_dly) begin
            clear_ack = 1;
            clr_dly = -1;
          end else begin
            clear_ack = 0;
            clr_cnt++;
          end
        end else begin
          clear_ack = spurious && ($urandom_range(3, 0) == 0);
        end
        if (char_req) begin
          if (chr_dly < 0) begin
            chr_dly = hold_next ? 20 : int'($urandom_range(dly_hi, dly_lo));
            hold_next = 0;
            chr_cnt = 0;
          end
          if (chr_cnt >= chr_dly) begin
            char_ack = 1;
            chr_dly = -1;
          end else begin
            char_ack = 0;
            chr_cnt++;
          end
        end else begin
          char_ack = spurious && ($urandom_range(3, 0) == 0);
        end
      end
    end
  end

  task automatic pulse_name(input logic [8*MAXN-1:0] b, input logic [5:0] l,
                            input logic [1:0] f);
    @(negedge system_clock);
    name_buffer = b;
    name_length = l;
    font_size   = f;
    name_ready  = 1;
    if (exp_q.size() == 0) begin
      if (!respawn_next) push_frame(b, l, f);
    end else begin
      model_pending = 1;
    end
    @(negedge system_clock);
    name_ready = 0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge system_clock);
      if (exp_q.size() == 0 && !model_pending && !respawn_next && !busy) begin
        ok = 1;
        break;
      end
    end
    check_eq("idle_reached", int'(ok), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_clear_req"},  int'(clear_req),  0);
    check_eq({tag, "_char_req"},   int'(char_req),   0);
    check_eq({tag, "_char_code"},  int'(char_code),  0);
    check_eq({tag, "_char_x"},     int'(char_x),     0);
    check_eq({tag, "_char_y"},     int'(char_y),     0);
    check_eq({tag, "_char_scale"}, int'(char_scale), 0);
    check_eq({tag, "_busy"},       int'(busy),       0);
    check_eq({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, clr0, chr0;
    bit found;
    logic [95:0] rnd;
    system_reset = 1;
    name_buffer  = '0;
    name_length  = '0;
    font_size    = '0;
    name_ready   = 0;
    repeat (3) @(negedge system_clock);
    check_all_zero("reset");
    system_reset = 0;

    // Basic render "AB"
    dly_lo = 1; dly_hi = 1; spurious = 0;
    fd0 = fd_count; clr0 = clr_count; chr0 = chr_count;
    pulse_name({64'h0, 8'h42, 8'h41}, 6'd2, 2'd0);
    wait_idle(200);
    repeat (3) @(negedge system_clock);
    check_eq("basic_frames", fd_count - fd0, 1);
    check_eq("basic_clears", clr_count - clr0, 1);
    check_eq("basic_chars",  chr_count - chr0, 2);
    check_eq("basic_busy_after", int'(busy), 0);

    // Scaling "XYZ" at font 2, inputs disturbed mid-frame
    dly_lo = 0; dly_hi = 2;
    chr0 = chr_count;
    pulse_name({56'h0, 8'h5A, 8'h59, 8'h58}, 6'd3, 2'd2);
    repeat (3) @(negedge system_clock);
    font_size   = 2'd0;
    name_buffer = {8*MAXN{1'b1}};
    wait_idle(300);
    check_eq("scale_chars", chr_count - chr0, 3);

    // Truncation at scale 4 and length clamp
    chr0 = chr_count;
    pulse_name(80'h4A494847464544434241, 6'd10, 2'd3);
    wait_idle(500);
    check_eq("trunc_chars", chr_count - chr0, 7);
    chr0 = chr_count;
    pulse_name(80'h4A494847464544434241, 6'd15, 2'd0);
    wait_idle(500);
    check_eq("clamp_chars", chr_count - chr0, 10);

    // Empty name
    fd0 = fd_count; clr0 = clr_count; chr0 = chr_count;
    pulse_name(80'h4A494847464544434241, 6'd0, 2'd1);
    wait_idle(200);
    check_eq("empty_frames", fd_count - fd0, 1);
    check_eq("empty_clears", clr_count - clr0, 1);
    check_eq("empty_chars",  chr_count - chr0, 0);

    // Back-pressure plus two collapsed pending requests
    fd0 = fd_count; clr0 = clr_count;
    hold_next = 1;
    pulse_name({40'h0, 8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48}, 6'd5, 2'd1);
    repeat (4) @(negedge system_clock);
    pulse_name({48'h0, 8'h34, 8'h33, 8'h32, 8'h31}, 6'd4, 2'd0);
    repeat (2) @(negedge system_clock);
    pulse_name({48'h0, 8'h34, 8'h33, 8'h32, 8'h31}, 6'd4, 2'd0);
    wait_idle(800);
    check_eq("pending_frames", fd_count - fd0, 2);
    check_eq("pending_clears", clr_count - clr0, 2);

    // Randomized frames with spurious acks and overlapping requests
    spurious = 1;
    for (int it = 0; it < 25; it++) begin
      dly_hi = int'($urandom_range(3, 0));
      rnd = {$urandom, $urandom, $urandom};
      pulse_name(rnd[8*MAXN-1:0], 6'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(25, 0)) @(negedge system_clock);
        rnd = {$urandom, $urandom, $urandom};
        pulse_name(rnd[8*MAXN-1:0], 6'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
      end
      wait_idle(1500);
    end

    // Reset abort while glyph 1 is requested
    spurious = 0; dly_lo = 1; dly_hi = 3;
    pulse_name({56'h0, 8'h43, 8'h42, 8'h41}, 6'd3, 2'd0);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge system_clock);
      if (char_req && exp_q.size() > 0 && exp_q[0].kind == 1 && exp_q[0].idx == 1) begin
        found = 1;
        break;
      end
    end
    check_eq("abort_reached_index1", int'(found), 1);
    system_reset = 1;
    exp_q.delete();
    model_pending = 0;
    respawn_next  = 0;
    #1;
    check_all_zero("abort");
    fd0 = fd_count;
    repeat (3) @(negedge system_clock);
    system_reset = 0;
    repeat (5) @(negedge system_clock);
    check_eq("abort_no_frame_done", fd_count - fd0, 0);
    chr0 = chr_count;
    pulse_name({56'h0, 8'h46, 8'h45, 8'h44}, 6'd3, 2'd1);
    wait_idle(300);
    check_eq("after_abort_chars", chr_count - chr0, 3);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
